// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the key pulse generator: per-key FSM state codes and
// default timing constants used by the conditioner and the top.
package key_pulse_gen_pkg;

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_DELAY = 2'd1,
    K_RPT   = 2'd2
  } key_state_e;

  localparam int unsigned DEF_CNT_W        = 24;
  localparam int unsigned DEF_DEB_CYCLES   = 40000;
  localparam int unsigned DEF_REPEAT_DELAY = 4000000;
  localparam int unsigned DEF_REPEAT_RATE  = 1000000;

endpackage

// File: rtl/key_pulse_gen_cond.sv
// One-key conditioner: 2-FF synchronizer, debouncer and press/hold-to-repeat FSM.
// fire_o flags the cycle before a pulse is due; the top registers it.
module key_pulse_gen_cond
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic fire_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 32'd1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  logic             sync1_q, sync2_q;
  logic             deb_level_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] rpt_cnt_q;
  key_state_e       state_q;
  logic             pressed_s;
  logic             fire_d;

  assign pressed_s = ~sync2_q;

  // Synchronizer resets to the released (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Level flips only once the counter has seen DEB_CYCLES disagreeing samples
  // and the current one still disagrees, so shorter glitches are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level_q <= 1'b0;
      deb_cnt_q   <= CNT_ZERO;
    end else if (pressed_s == deb_level_q) begin
      deb_cnt_q <= CNT_ZERO;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_level_q <= pressed_s;
      deb_cnt_q   <= CNT_ZERO;
    end else begin
      deb_cnt_q <= sat_inc(deb_cnt_q);
    end
  end

  // A release always wins over a due repeat, so releasing never fires.
  always_comb begin
    fire_d = 1'b0;
    case (state_q)
      K_IDLE:  fire_d = deb_level_q;
      K_DELAY: fire_d = deb_level_q && (rpt_cnt_q == DELAY_LAST);
      K_RPT:   fire_d = deb_level_q && (rpt_cnt_q == RATE_LAST);
      default: fire_d = 1'b0;
    endcase
  end

  // Press / delay / repeat sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= K_IDLE;
      rpt_cnt_q <= CNT_ZERO;
    end else begin
      case (state_q)
        K_IDLE: begin
          rpt_cnt_q <= CNT_ZERO;
          if (deb_level_q) begin
            state_q <= K_DELAY;
          end
        end
        K_DELAY: begin
          if (!deb_level_q) begin
            state_q   <= K_IDLE;
            rpt_cnt_q <= CNT_ZERO;
          end else if (fire_d) begin
            state_q   <= K_RPT;
            rpt_cnt_q <= CNT_ZERO;
          end else begin
            rpt_cnt_q <= sat_inc(rpt_cnt_q);
          end
        end
        K_RPT: begin
          if (!deb_level_q) begin
            state_q   <= K_IDLE;
            rpt_cnt_q <= CNT_ZERO;
          end else if (fire_d) begin
            rpt_cnt_q <= CNT_ZERO;
          end else begin
            rpt_cnt_q <= sat_inc(rpt_cnt_q);
          end
        end
        default: begin
          state_q   <= K_IDLE;
          rpt_cnt_q <= CNT_ZERO;
        end
      endcase
    end
  end

  assign fire_o = fire_d;
  assign held_o = deb_level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Two-key increment/decrement pulse generator feeding the timer count-adjust logic.
// Same-cycle up/down requests cancel; en masks pulses without stalling the keys.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic countUp,
  input  logic countDn,
  output logic up_pulse,
  output logic dn_pulse,
  output logic up_held,
  output logic dn_held
);

  logic up_fire_s;
  logic dn_fire_s;

  key_pulse_gen_cond #(
    .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_up (
    .clk(clk), .rst_n(rst_n), .key_n_i(countUp),
    .fire_o(up_fire_s), .held_o(up_held)
  );

  key_pulse_gen_cond #(
    .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) u_dn (
    .clk(clk), .rst_n(rst_n), .key_n_i(countDn),
    .fire_o(dn_fire_s), .held_o(dn_held)
  );

  // Registered pulses: coincident requests net to zero, masked ones are lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
    end else begin
      up_pulse <= en & up_fire_s & ~dn_fire_s;
      dn_pulse <= en & dn_fire_s & ~up_fire_s;
    end
  end

endmodule
